// File: rtl/alu_op_sequencer_if.sv
// Command, response and ALU bundle for alu_op_sequencer.
// master = issue logic plus the shared ALU; slave = the sequencer itself.
interface alu_op_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_lo;
    logic [WIDTH-1:0] rsp_hi;
    logic             rsp_c;
    logic             rsp_v;
    logic             rsp_z;
    logic             rsp_n;

    logic             alu_add_sub;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_s;
    logic             alu_c;
    logic             alu_v;
    logic             alu_z;
    logic             alu_n;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
               alu_s, alu_c, alu_v, alu_z, alu_n,
        input  cmd_ready, rsp_valid, rsp_lo, rsp_hi, rsp_c, rsp_v, rsp_z, rsp_n,
               alu_add_sub, alu_a, alu_b
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
               alu_s, alu_c, alu_v, alu_z, alu_n,
        output cmd_ready, rsp_valid, rsp_lo, rsp_hi, rsp_c, rsp_v, rsp_z, rsp_n,
               alu_add_sub, alu_a, alu_b
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// ADD/SUB/CMP/MUL command sequencer driving a shared external add/sub ALU.
// Optional macro ALU_SEQ_SAT_EN: signed saturation of ADD/SUB results on overflow.
module alu_op_sequencer #(
    parameter int WIDTH     = 16,
    parameter int MUL_STEPS = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               busy,
    alu_op_sequencer_if.slave  bus
);
    localparam int CNT_W = $clog2(MUL_STEPS);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_CMP = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_MUL,
        S_RESP
    } state_t;

    state_t             state_q,     state_d;
    op_t                op_q,        op_d;
    logic [WIDTH-1:0]   opa_q,       opa_d;
    logic [WIDTH-1:0]   opb_q,       opb_d;
    logic [WIDTH-1:0]   acc_hi_q,    acc_hi_d;
    logic [WIDTH-1:0]   q_q,         q_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]   rsp_lo_q,    rsp_lo_d;
    logic [WIDTH-1:0]   rsp_hi_q,    rsp_hi_d;
    logic               rsp_c_q,     rsp_c_d;
    logic               rsp_v_q,     rsp_v_d;
    logic               rsp_z_q,     rsp_z_d;
    logic               rsp_n_q,     rsp_n_d;

    logic               alu_add_sub_w;
    logic [WIDTH-1:0]   alu_a_w;
    logic [WIDTH-1:0]   alu_b_w;
    logic [2*WIDTH:0]   mul_full;
    logic [2*WIDTH-1:0] mul_next;
`ifdef ALU_SEQ_SAT_EN
    logic               sat_neg;
`endif

    // One shift-add step: ALU carry becomes the new MSB of the 2*WIDTH accumulator.
    assign mul_full = {bus.alu_c, bus.alu_s, q_q};
    assign mul_next = mul_full[2*WIDTH:1];

    always_comb begin
        // NOTE: every variable gets a default here so no path leaves it unassigned (no latches).
        state_d       = state_q;
        op_d          = op_q;
        opa_d         = opa_q;
        opb_d         = opb_q;
        acc_hi_d      = acc_hi_q;
        q_d           = q_q;
        cnt_d         = cnt_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_lo_d      = rsp_lo_q;
        rsp_hi_d      = rsp_hi_q;
        rsp_c_d       = rsp_c_q;
        rsp_v_d       = rsp_v_q;
        rsp_z_d       = rsp_z_q;
        rsp_n_d       = rsp_n_q;
        alu_add_sub_w = 1'b0;
        alu_a_w       = '0;
        alu_b_w       = '0;
`ifdef ALU_SEQ_SAT_EN
        sat_neg       = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    op_d  = op_t'(bus.cmd_op);
                    opa_d = bus.cmd_a;
                    opb_d = bus.cmd_b;
                    if (op_t'(bus.cmd_op) == OP_MUL) begin
                        acc_hi_d = '0;
                        q_d      = bus.cmd_b;
                        cnt_d    = '0;
                        state_d  = S_MUL;
                    end else begin
                        state_d  = S_EXEC;
                    end
                end
            end

            S_EXEC: begin
                alu_a_w       = opa_q;
                alu_b_w       = opb_q;
                alu_add_sub_w = (op_q != OP_ADD);
                rsp_lo_d      = (op_q == OP_CMP) ? opa_q : bus.alu_s;
                rsp_hi_d      = '0;
                rsp_c_d       = bus.alu_c;
                rsp_v_d       = bus.alu_v;
                rsp_z_d       = bus.alu_z;
                rsp_n_d       = bus.alu_n;
`ifdef ALU_SEQ_SAT_EN
                // On overflow the true sign is the sign of A (ADD) or of -B (SUB).
                if (op_q != OP_CMP && bus.alu_v) begin
                    sat_neg  = (op_q == OP_ADD) ? opa_q[WIDTH-1] : ~opb_q[WIDTH-1];
                    rsp_lo_d = sat_neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
                    rsp_n_d  = sat_neg;
                    rsp_z_d  = 1'b0;
                end
`endif
                rsp_valid_d   = 1'b1;
                state_d       = S_RESP;
            end

            S_MUL: begin
                alu_a_w       = acc_hi_q;
                alu_b_w       = q_q[0] ? opa_q : '0;
                alu_add_sub_w = 1'b0;
                acc_hi_d      = mul_next[2*WIDTH-1:WIDTH];
                q_d           = mul_next[WIDTH-1:0];
                cnt_d         = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(MUL_STEPS - 1)) begin
                    rsp_hi_d    = mul_next[2*WIDTH-1:WIDTH];
                    rsp_lo_d    = mul_next[WIDTH-1:0];
                    rsp_c_d     = 1'b0;
                    rsp_v_d     = |mul_next[2*WIDTH-1:WIDTH];
                    rsp_z_d     = ~|mul_next;
                    rsp_n_d     = mul_next[2*WIDTH-1];
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end
            end

            S_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the async reset
    // clears every register, including operands and accumulator, so an aborted MUL leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= OP_ADD;
            opa_q       <= '0;
            opb_q       <= '0;
            acc_hi_q    <= '0;
            q_q         <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_lo_q    <= '0;
            rsp_hi_q    <= '0;
            rsp_c_q     <= 1'b0;
            rsp_v_q     <= 1'b0;
            rsp_z_q     <= 1'b0;
            rsp_n_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            acc_hi_q    <= acc_hi_d;
            q_q         <= q_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_lo_q    <= rsp_lo_d;
            rsp_hi_q    <= rsp_hi_d;
            rsp_c_q     <= rsp_c_d;
            rsp_v_q     <= rsp_v_d;
            rsp_z_q     <= rsp_z_d;
            rsp_n_q     <= rsp_n_d;
        end
    end

    assign busy            = (state_q != S_IDLE);
    assign bus.cmd_ready   = (state_q == S_IDLE);
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_lo      = rsp_lo_q;
    assign bus.rsp_hi      = rsp_hi_q;
    assign bus.rsp_c       = rsp_c_q;
    assign bus.rsp_v       = rsp_v_q;
    assign bus.rsp_z       = rsp_z_q;
    assign bus.rsp_n       = rsp_n_q;
    assign bus.alu_add_sub = alu_add_sub_w;
    assign bus.alu_a       = alu_a_w;
    assign bus.alu_b       = alu_b_w;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: behavioural ALU, arithmetic reference model,
// directed plan cases, backpressure, mid-MUL reset and randomized commands.
module tb_alu_op_sequencer;
    localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, MUL = 2'b10, CMP = 2'b11;

    logic clk;
    logic rst_n;
    logic busy;
    int   checks   = 0;
    int   failures = 0;

    alu_op_sequencer_if #(.WIDTH(16)) bus ();

    alu_op_sequencer #(.WIDTH(16), .MUL_STEPS(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .busy  (busy),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU: subtract is A + ~B + 1, so C means "no borrow".
    logic [16:0] alu_t;
    logic [15:0] alu_bm;
    always_comb begin
        alu_bm    = bus.alu_add_sub ? ~bus.alu_b : bus.alu_b;
        alu_t     = {1'b0, bus.alu_a} + {1'b0, alu_bm} + {16'd0, bus.alu_add_sub};
        bus.alu_s = alu_t[15:0];
        bus.alu_c = alu_t[16];
        bus.alu_v = (bus.alu_a[15] == alu_bm[15]) && (alu_t[15] != bus.alu_a[15]);
        bus.alu_z = (alu_t[15:0] == 16'd0);
        bus.alu_n = alu_t[15];
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Reference model from the arithmetic definition of each command.
    function automatic void model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] lo, output logic [15:0] hi,
                                  output logic c, output logic v, output logic z, output logic n);
        int          ua, ub, sa, sb, tr;
        longint      p;
        logic [31:0] pr;
        logic [15:0] d;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        hi = 16'd0;
        if (op == MUL) begin
            p  = longint'(ua) * longint'(ub);
            pr = p[31:0];
            hi = pr[31:16];
            lo = pr[15:0];
            c  = 1'b0;
            v  = (hi != 16'd0);
            z  = (pr == 32'd0);
            n  = pr[31];
        end else begin
            if (op == ADD) begin
                tr = sa + sb;
                d  = 16'(ua + ub);
                c  = (ua + ub) > 65535;
            end else begin
                tr = sa - sb;
                d  = 16'(ua - ub);
                c  = (ua >= ub);
            end
            v  = (tr > 32767) || (tr < -32768);
            z  = (d == 16'd0);
            n  = d[15];
            lo = (op == CMP) ? a : d;
`ifdef ALU_SEQ_SAT_EN
            if (op != CMP && v) begin
                lo = (tr > 0) ? 16'h7FFF : 16'h8000;
                n  = lo[15];
                z  = 1'b0;
            end
`endif
        end
    endfunction

    task automatic check_rsp(input string tag, input logic [15:0] lo, input logic [15:0] hi,
                             input logic c, input logic v, input logic z, input logic n);
        check({tag, "_valid"}, bus.rsp_valid, 1'b1);
        check({tag, "_lo"},    bus.rsp_lo, lo);
        check({tag, "_hi"},    bus.rsp_hi, hi);
        check({tag, "_flags"}, {bus.rsp_c, bus.rsp_v, bus.rsp_z, bus.rsp_n}, {c, v, z, n});
    endtask

    // Called at a negedge with the sequencer idle; returns at a negedge, idle again.
    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [15:0] a,
                           input logic [15:0] b, input int hold);
        logic [15:0] lo, hi;
        logic        c, v, z, n;
        int          edges;
        model(op, a, b, lo, hi, c, v, z, n);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        check({tag, "_ready"}, bus.cmd_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        edges = 1;
        while (!bus.rsp_valid && edges < 40) begin
            @(negedge clk);
            edges++;
        end
        check({tag, "_latency"}, edges, (op == MUL) ? 17 : 2);
        check_rsp(tag, lo, hi, c, v, z, n);
        // A competing command while busy must be ignored.
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = ADD;
        bus.cmd_a     = 16'h1111;
        bus.cmd_b     = 16'h2222;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_rsp({tag, "_hold"}, lo, hi, c, v, z, n);
            check({tag, "_hold_ctl"}, {bus.cmd_ready, busy}, 2'b01);
            check({tag, "_hold_alu"}, {bus.alu_add_sub, bus.alu_a, bus.alu_b}, 33'd0);
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check({tag, "_taken"}, {bus.rsp_valid, bus.cmd_ready, busy}, 3'b010);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_a     = 16'd0;
        bus.cmd_b     = 16'd0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ctl", {bus.cmd_ready, busy, bus.rsp_valid}, 3'b100);
        check("reset_rsp", {bus.rsp_hi, bus.rsp_lo}, 32'd0);
        check("reset_alu", {bus.alu_add_sub, bus.alu_a, bus.alu_b}, 33'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_cmd("add_plan",  ADD, 16'h0A0A, 16'hB0B0, 1);
        run_cmd("sub_plan",  SUB, 16'h8888, 16'h1111, 0);
        run_cmd("cmp_plan",  CMP, 16'h8888, 16'h1111, 0);
        run_cmd("mul_plan",  MUL, 16'h1234, 16'h0010, 0);
        run_cmd("mul_max",   MUL, 16'hFFFF, 16'hFFFF, 1);
        run_cmd("mul_zero",  MUL, 16'h5555, 16'h0000, 0);
        run_cmd("add_ovf",   ADD, 16'h7FFF, 16'h0001, 0);
        run_cmd("sub_ovf",   SUB, 16'h8000, 16'h0001, 0);
        run_cmd("add_novf",  ADD, 16'h8000, 16'h8000, 0);
        run_cmd("backpress", SUB, 16'h0005, 16'h0009, 5);
        run_cmd("back2back", MUL, 16'h00FF, 16'h0101, 0);

        // Abort a MUL after step 7 with reset.
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = MUL;
        bus.cmd_a     = 16'hFFFF;
        bus.cmd_b     = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (7) @(negedge clk);
        check("mul_mid_busy", busy, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("abort_ctl", {bus.cmd_ready, busy, bus.rsp_valid}, 3'b100);
        check("abort_alu", {bus.alu_add_sub, bus.alu_a, bus.alu_b}, 33'd0);
        check("abort_rsp", {bus.rsp_hi, bus.rsp_lo}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_idle", {bus.cmd_ready, busy, bus.rsp_valid}, 3'b100);
        run_cmd("add_1_1", ADD, 16'h0001, 16'h0001, 0);

        for (int i = 0; i < 40; i++) begin
            run_cmd("rand", 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
                    int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Command sequencer in front of the shared 16-bit add/sub ALU (ports add_sub, A, B → S, C, V, Z, N).
- Accepts ADD/SUB/CMP/MUL commands over a valid/ready handshake and drives the external ALU.
- Single-cycle ops make one ALU pass; MUL is a 16-step unsigned shift-add loop through the ALU adder.
- Returns a 32-bit result plus flags over a valid/ready response channel. Sits between decode/issue and the ALU in the RISC16bit core.

Parameters:
WIDTH, 16, datapath width; only 16 is supported.
MUL_STEPS, 16, MUL iterations; must equal WIDTH.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  sequencer can accept a command.
cmd_op  in  2  00 ADD, 01 SUB, 10 MUL, 11 CMP.
cmd_a  in  16  operand A / multiplicand.
cmd_b  in  16  operand B / multiplier.
rsp_valid  out  1  response present.
rsp_ready  in  1  consumer accepts the response.
rsp_lo  out  16  result low word.
rsp_hi  out  16  MUL high word; 0 for other ops.
rsp_c, rsp_v, rsp_z, rsp_n  out  1 each  result flags.
busy  out  1  high whenever state is not IDLE.
alu_add_sub  out  1  to ALU: 0 = add, 1 = subtract.
alu_a, alu_b  out  16 each  ALU operands.
alu_s  in  16  ALU sum.
alu_c, alu_v, alu_z, alu_n  in  1 each  ALU flags.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- While rst_n is low:
  - state = IDLE; all response registers 0; rsp_valid = 0; busy = 0.
  - Operand, accumulator and count registers cleared.
  - Since state is IDLE, cmd_ready = 1.
- Reset asserted mid-operation aborts the operation; no response is produced.
- States:
  - IDLE: cmd_ready = 1. On the edge where cmd_valid & cmd_ready, latch op/a/b. Go to EXEC for ADD/SUB/CMP. For MUL, clear acc_hi and cnt, load q = cmd_b, go to MUL.
  - EXEC (1 cycle): drive alu_a = opa, alu_b = opb, alu_add_sub = (op != ADD).
    - At the edge, capture alu_c/v/z/n into the rsp flags.
    - rsp_lo = alu_s for ADD/SUB; rsp_lo = opa for CMP. rsp_hi = 0. Go to RESP.
  - MUL (16 cycles): drive alu_a = acc_hi, alu_b = q[0] ? opa : 0, alu_add_sub = 0.
    - Each edge: {acc_hi, q} <= {alu_c, alu_s, q} >> 1; cnt++.
    - After the edge where cnt reaches 15: rsp_hi = acc_hi, rsp_lo = q, computed from the final-step values.
    - MUL flags: C = 0, V = (rsp_hi != 0), Z = (32-bit result == 0), N = result[31]. Go to RESP.
  - RESP: rsp_valid = 1. Response fields held stable until rsp_valid & rsp_ready, then go to IDLE.
- cmd_ready = (state == IDLE). No new command is accepted in the cycle the response is taken; the next acceptance is one cycle later.
- Latency from the accept edge to rsp_valid high: ADD/SUB/CMP 2 edges; MUL 17 edges.
- Outside EXEC/MUL: alu_a = alu_b = 0, alu_add_sub = 0.
- Arithmetic is modulo 2^16 per ALU pass. The MUL product is unsigned 32-bit and exact, including 0xFFFF × 0xFFFF.
- Edge cases: MUL by 0 gives result 0 with Z = 1. cmd_valid asserted while not IDLE is ignored; the command must be held by the requester.

Optional Feature:
ALU_SEQ_SAT_EN.
- Defined: for ADD/SUB, when alu_v = 1, rsp_lo saturates to 0x7FFF if the true signed result is positive, or 0x8000 if negative. Sign is taken from opa[15] for ADD and from ~opb[15] for SUB.
  - rsp_v stays 1. rsp_n and rsp_z are recomputed from the saturated value.
- Undefined: rsp_lo = alu_s wraps. CMP and MUL are unaffected in both builds.

Test Plan:
- ADD A=0x0A0A, B=0xB0B0 → rsp_lo=0xBABA, hi=0, N=1, Z=0, V=0, C=0; rsp_valid 2 edges after accept.
- SUB A=0x8888, B=0x1111 → rsp_lo=0x7777, V=1, N=0, Z=0. CMP with the same operands → rsp_lo=0x8888, same flags.
- MUL A=0x1234, B=0x0010 → hi=0x0001, lo=0x2340, V=1, Z=0. MUL 0xFFFF × 0xFFFF → hi=0xFFFE, lo=0x0001, N=1. MUL A=0x5555, B=0 → 0, Z=1. rsp_valid on the 17th edge after accept.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid → outputs stable, cmd_ready=0, busy=1. On release, IDLE one cycle later and a back-to-back command is accepted.
- Reset: drop rst_n at MUL step 7 → immediate IDLE, rsp_valid=0, alu_* = 0. After release, ADD 1+1 → rsp_lo=0x0002.
- ADD 0x7FFF + 0x0001 → with ALU_SEQ_SAT_EN: rsp_lo=0x7FFF, V=1, N=0. Without: rsp_lo=0x8000, V=1, N=1.
